// File: rtl/pipelined_select_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_select_subtractor
//
// Pipelined WIDTH-bit subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin. One SLICE-bit slice is resolved per stage. Each stage forms
// both carry candidates (carry-in 0 and carry-in 1) for its slice. The carry
// registered by the previous stage then picks one of them. Stage 0 uses
// ~in_bin as its carry-in.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   pipeline accepts operands this cycle (combinational)
//   in_a       minuend, WIDTH bits
//   in_b       subtrahend, WIDTH bits
//   in_bin     borrow-in
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_diff   (in_a - in_b - in_bin) mod 2^WIDTH
//   out_borrow 1 when unsigned in_a < in_b + in_bin
//   out_zero   out_diff == 0
//   out_ovf    two's-complement overflow of the signed subtraction
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never waits on ready. Once out_valid is raised, it and every
// result output stay stable until a cycle with out_ready high. The whole
// pipeline advances as one unit (en = !out_valid || out_ready). in_ready is
// en, so operands are accepted exactly when the pipeline shifts. Empty slots
// (bubbles) travel with the pipeline and are never collapsed.
//
// WIDTH must be a multiple of SLICE and at least SLICE. STAGES is derived
// from these two and cannot be overridden.
// ---------------------------------------------------------------------------
module pipelined_select_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SLICE;

    // Global advance enable
    logic en;

    // Stage registers. Each stage carries the full operands forward. The
    // lower slices of these operands are already consumed, and synthesis
    // trims them. The MSBs must reach the end of the pipeline because the
    // overflow flag needs them.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  d_q [STAGES];

    // Inputs seen by each stage: the raw ports for stage 0, and the previous
    // stage register for every other stage.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_d [STAGES];

    // Per-stage carry-select arithmetic, SLICE+1 bits wide
    logic [SLICE:0]    sum0 [STAGES];
    logic [SLICE:0]    sum1 [STAGES];
    logic [SLICE:0]    sel  [STAGES];
    logic [WIDTH-1:0]  nxt_d [STAGES];
    logic [STAGES-1:0] nxt_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        src_v    = '0;
        src_c    = '0;
        src_v[0] = in_valid;
        src_c[0] = ~in_bin;
        src_a[0] = in_a;
        src_b[0] = in_b;
        src_d[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            // Both candidates are computed without waiting for the incoming
            // carry. The carry only drives the final 2:1 select.
            sum0[k]  = {1'b0, src_a[k][k*SLICE +: SLICE]}
                     + {1'b0, ~src_b[k][k*SLICE +: SLICE]};
            sum1[k]  = sum0[k] + {{SLICE{1'b0}}, 1'b1};
            sel[k]   = src_c[k] ? sum1[k] : sum0[k];
            nxt_d[k] = src_d[k];
            nxt_d[k][k*SLICE +: SLICE] = sel[k][SLICE-1:0];
            nxt_c[k] = sel[k][SLICE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else if (en) begin
            v_q <= src_v;
            c_q <= nxt_c;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                d_q[k] <= nxt_d[k];
            end
        end
    end

    // The final stage register drives the result directly. The flags are
    // gated with valid, so an empty final slot reports all-zero flags. This
    // also covers the reset state, where the raw carry and diff would
    // otherwise read as borrow=1 and zero=1.
    assign out_valid  = v_q[STAGES-1];
    assign out_diff   = d_q[STAGES-1];
    assign out_borrow = out_valid & ~c_q[STAGES-1];
    assign out_zero   = out_valid & (d_q[STAGES-1] == '0);
    assign out_ovf    = out_valid
                      & (a_q[STAGES-1][WIDTH-1] != b_q[STAGES-1][WIDTH-1])
                      & (d_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_select_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipelined_select_subtractor
//
// Directed bench for pipelined_select_subtractor at WIDTH=16, SLICE=4.
// A reference model in plain integer arithmetic predicts every result. A
// scoreboard checks each valid output cycle against that model. Directed
// sequences also pin literal values, latency, stall behaviour and reset.
// ---------------------------------------------------------------------------
module tb_pipelined_select_subtractor;

    localparam int W      = 16;
    localparam int STAGES = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_bin;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready;
    logic [W-1:0] out_diff;
    logic         out_borrow, out_zero, out_ovf;

    pipelined_select_subtractor #(.WIDTH(W), .SLICE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_bin     (in_bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packs {diff[15:0], borrow, zero, ovf}
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0]   full;
        logic [W-1:0] d;
        int           sa, sb, sd;
        logic         ovf;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d    = full[W-1:0];
        sa   = $signed(a);
        sb   = $signed(b);
        sd   = sa - sb - int'(bin);
        ovf  = (sd > 32767) || (sd < -32768);
        return {d, full[W], (d == '0), ovf};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+2:0] exp_q[$];
    logic         held_valid = 1'b0;
    logic [W+2:0] held;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held_valid) begin
                check("stall_valid", out_valid, 1);
                check("stall_stable", {out_diff, out_borrow, out_zero, out_ovf}, held);
                held_valid = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("result", {out_diff, out_borrow, out_zero, out_ovf}, exp_q[0]);
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    held_valid = 1'b1;
                    held       = {out_diff, out_borrow, out_zero, out_ovf};
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_bin));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with the pipeline empty and out_ready high.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input logic [W-1:0] e_d, input logic e_br, input logic e_z,
                            input logic e_ov);
        int n;
        check("model_pin", model(a, b, bin), {e_d, e_br, e_z, e_ov});
        in_valid = 1'b1; in_a = a; in_b = b; in_bin = bin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n + 1, STAGES);
        check("lit_diff", out_diff, e_d);
        check("lit_borrow", out_borrow, e_br);
        check("lit_zero", out_zero, e_z);
        check("lit_ovf", out_ovf, e_ov);
        @(posedge clk); #1;
        check("one_cycle_pulse", out_valid, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] lit4 [3];
        logic [W-1:0] ta, tb;
        lit4 = '{16'h001E, 16'h002D, 16'h003C};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0; out_ready = 1'b1;
        idle(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_diff", out_diff, 0);
        check("rst_out_borrow", out_borrow, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(1);

        // Basic, borrow/overflow and zero/bin corners
        send_one(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        send_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        send_one(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        send_one(16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send_one(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Four back-to-back accepts, then a 3-cycle stall on the first result
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = W'((i + 1) * 16); in_b = W'(i + 1); in_bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_diff", out_diff, 16'h000F);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_diff", out_diff, 16'h000F);
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("drain_valid", out_valid, 1);
            check("drain_diff", out_diff, lit4[j]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("drain_done", out_valid, 0);
        @(posedge clk); #1;
        idle(2);

        // 20 consecutive accepts at full throughput
        for (int i = 0; i < 25; i++) begin
            if (i < 20) begin
                ta = W'(i * 32'h1357 + 32'h0101);
                tb = W'(i * 32'h2468) ^ 16'h00FF;
                in_valid = 1'b1; in_a = ta; in_b = tb; in_bin = 1'(i % 2);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 20) check("stream_in_ready", in_ready, 1);
            check("stream_out_valid", out_valid, (i >= 4 && i < 24) ? 1 : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(2);

        // Asynchronous reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = W'(16'h0100 + i); in_b = W'(i); in_bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_diff", out_diff, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
            @(posedge clk); #1;
        end
        send_one(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        idle(3);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
